// File: rtl/button_ctrl_pkg.sv
// Shared types and constants for the front-panel button controller.
// Debounce FSM states and the default 10 ms debounce length at 125 MHz.
package button_ctrl_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_125M = 1250000;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, debounce FSM and stability counter.
// Emits a registered one-cycle press pulse and a debounced level.
module btn_debounce
  import button_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_125M,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pressed_pulse,
  output logic level,
  output logic press_fire
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= RELEASED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!sync2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (sync2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == RELEASE_CHK);
  end

  // press_fire lets the owner toggle on the same edge the pulse rises
  assign press_fire    = pulse_d;
  assign pressed_pulse = pulse_q;
  assign level         = level_q;

endmodule

// File: rtl/button_ctrl.sv
// Front-panel control: debounced run/stop and up/down toggles
// feeding the LED counter's enable and dir inputs.
module button_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_125M,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_run,
  input  logic btn_dir,
  output logic enable,
  output logic dir,
  output logic run_press,
  output logic dir_press
);

  logic run_fire, dir_fire;
  logic run_level, dir_level;
  logic enable_q, enable_d;
  logic dir_q, dir_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_run (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn_run),
    .pressed_pulse(run_press),
    .level        (run_level),
    .press_fire   (run_fire)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_dir (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn_dir),
    .pressed_pulse(dir_press),
    .level        (dir_level),
    .press_fire   (dir_fire)
  );

  always_comb begin
    enable_d = enable_q ^ run_fire;
    dir_d    = dir_q ^ dir_fire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      enable_q <= enable_d;
      dir_q    <= dir_d;
    end
  end

  assign enable = enable_q;
  assign dir    = dir_q;

  logic unused_levels;
  assign unused_levels = run_level ^ dir_level;

endmodule
